// File: rtl/monishvr_fifo_pkg.sv
// Shared sizing and pin-map constants for the monishvr_fifo wrapper and its core.
package monishvr_fifo_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = $clog2(DEPTH);

  localparam int unsigned WR_EN_BIT = 2;
  localparam int unsigned RD_EN_BIT = 3;
  localparam int unsigned DIN_LSB   = 4;

  localparam int unsigned FULL_BIT  = 0;
  localparam int unsigned EMPTY_BIT = 1;
  localparam int unsigned DOUT_LSB  = 2;
  localparam int unsigned OVF_BIT   = 6;
  localparam int unsigned UNF_BIT   = 7;

endpackage

// File: rtl/monishvr_fifo_core.sv
// Generic synchronous FIFO: storage, pointers, occupancy count, registered read data
// and sticky overflow/underflow flags.
module fifo_core
  import monishvr_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count;
  logic              rd_ok;
  logic              wr_ok;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is still legal when a read frees a slot on the same edge.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && rst_n) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full && !rd_ok) overflow  <= 1'b1;
      if (rd_en && empty && !wr_en) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/monishvr_fifo.sv
// TinyTapeout-style wrapper: maps fifo_core onto the ui/uo/uio pin buses.
module monishvr_fifo
  import monishvr_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
  logic              unused_pins;

  assign unused_pins = &{1'b0, ena, uio_in, ui_in[1:0]};

  fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (ui_in[WR_EN_BIT]),
    .rd_en     (ui_in[RD_EN_BIT]),
    .din       (ui_in[DIN_LSB +: DATA_W]),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_comb begin
    uo_out                      = '0;
    uo_out[FULL_BIT]            = full;
    uo_out[EMPTY_BIT]           = empty;
    uo_out[DOUT_LSB +: DATA_W]  = dout;
    uo_out[OVF_BIT]             = overflow;
    uo_out[UNF_BIT]             = underflow;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_monishvr_fifo.sv
// Scoreboard bench for monishvr_fifo: stimulus pushes expected uo_out per cycle,
// a monitor pops and compares after each rising edge.
module tb_monishvr_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  monishvr_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q [$];
  string      nm_q [$];

  logic [3:0] mq [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [3:0] m_rdata = '0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic op(input logic wr, input logic rd, input logic [3:0] d, input string nm);
    logic full_m, empty_m, rd_ok, wr_ok;
    @(negedge clk);
    ui_in = {d, rd, wr, 2'($urandom_range(0, 3))};
    full_m  = (mq.size() == 16);
    empty_m = (mq.size() == 0);
    rd_ok = rd && !empty_m;
    wr_ok = wr && (!full_m || rd_ok);
    if (rd && empty_m && !wr) m_unf = 1'b1;
    if (wr && full_m && !rd_ok) m_ovf = 1'b1;
    if (rd_ok) m_rdata = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    sb_q.push_back({m_unf, m_ovf, m_rdata, mq.size() == 0, mq.size() == 16});
    nm_q.push_back(nm);
    @(posedge clk);
    #2;
    ui_in[3:2] = 2'b00;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", uo_out, 8'h02);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [7:0] e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n = nm_q.pop_front();
        chk(n, uo_out, e);
        chk({n, "_uio_out"}, uio_out, 8'h00);
        chk({n, "_uio_oe"}, uio_oe, 8'h00);
      end
    end
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    chk("reset_state", uo_out, 8'h02);
    rst_n = 1'b1;

    // reset mid-operation with data stored, then read-while-empty
    for (int i = 1; i <= 3; i++) op(1'b1, 1'b0, 4'(i), "pre_wr");
    do_reset();
    op(1'b0, 1'b1, 4'h0, "rd_empty");
    chk("underflow_set", uo_out, 8'h82);
    do_reset();

    // single write / read
    op(1'b1, 1'b0, 4'hA, "wr_A");
    chk("after_wr_A", uo_out, 8'h00);
    op(1'b0, 1'b1, 4'h0, "rd_A");
    chk("after_rd_A", uo_out, 8'h2A);
    op(1'b1, 1'b0, 4'hC, "wr_C");
    op(1'b0, 1'b1, 4'h0, "rd_C");
    chk("after_rd_C", uo_out, 8'h32);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'(i), "fill");
    chk("full_after_16", uo_out, 8'h31);
    op(1'b1, 1'b0, 4'h5, "overflow_wr");
    chk("overflow_set", uo_out, 8'h71);
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 4'h0, "drain");
    chk("drained_F", uo_out, 8'h7E);
    do_reset();

    // wrap-around
    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 4'(i), "wrap_wr10");
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, 4'h0, "wrap_rd10");
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'((i + 1) % 16), "wrap_wr16");
    chk("wrap_full", uo_out, 8'h25);
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 4'h0, "wrap_rd16");
    chk("wrap_drained", uo_out, 8'h02);

    // simultaneous at full
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'(i), "sim_fill");
    op(1'b1, 1'b1, 4'h7, "sim_full_wr_rd");
    chk("sim_full", uo_out, 8'h01);
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 4'h0, "sim_drain");
    chk("sim_last_7", uo_out, 8'h1E);

    // simultaneous at empty
    op(1'b1, 1'b1, 4'h3, "sim_empty_wr_rd");
    chk("sim_empty", uo_out, 8'h1C);
    op(1'b0, 1'b1, 4'h0, "sim_rd_3");
    chk("sim_read_3", uo_out, 8'h0E);

    // ena and uio_in are ignored
    ena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      uio_in = 8'($urandom);
      op(i[0], !i[0], 4'(9 - i), "tie_offs");
    end
    ena = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
